axis_width_downconverter: RTL and testbench
===========================================

# axis_width_downconverter

Parametrised AXI4-Stream down-converter that splits each wide input beat of RATIO×OUT_BYTES bytes into up to RATIO narrow output beats of OUT_BYTES bytes. It skips sub-words whose tkeep is entirely zero and moves tlast onto the final non-empty sub-word. It sits between a wide result producer (e.g. the 1024-bit partitioned hash-join output) and the 512-bit host send stream. It generalises the fixed 1024→512 converter to any ratio and adds empty-lane compaction.

## Interface
Parameters:
- OUT_BYTES, 64, bytes per output beat; output data width = 8·OUT_BYTES.
- RATIO, 2, input/output width ratio; legal values 2..8.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  8·OUT_BYTES·RATIO  wide input data; lane k = bits [8·OUT_BYTES·(k+1)-1 : 8·OUT_BYTES·k]
- in_keep  in  OUT_BYTES·RATIO  byte enables
- in_valid  in  1  input beat valid
- in_last  in  1  input end of packet
- in_ready  out  1  input accepted when in_valid && in_ready
- out_data  out  8·OUT_BYTES  output lane data
- out_keep  out  OUT_BYTES  output lane byte enables
- out_valid  out  1  output beat valid
- out_last  out  1  output end of packet
- out_ready  in  1  downstream ready
- beat_count  out  32  number of output beats transferred since reset; wraps at 2^32

## Operation
- Holding register: one wide beat (data, keep, last), a `full` flag, and lane index `sel` (width clog2(RATIO)).
- Lane non-empty mask: nz[k] = OR of in_keep bits of lane k. Computed at capture and stored.
- Capture, when an input beat is accepted:
  - nz≠0: store the beat, full=1, sel = lowest set bit of nz.
  - nz=0 and in_last=1: store the beat, full=1, sel=0. Emit one beat with keep=0 and last=1 so the packet terminates.
  - nz=0 and in_last=0: beat consumed and discarded, full=0.
- Output while full: out_valid=1. out_data/out_keep = lane sel. out_last = held_last && no nz bit above sel.
- `final` = no nz bit above sel, or the zero-keep-last case.
- On out_valid && out_ready:
  - not final: sel jumps to the next set nz bit above sel. Lanes with zero keep are never emitted.
  - final: full=0, unless an input beat is accepted in the same cycle.
- in_ready = !full || (out_ready && final). A new wide beat is captured in the same cycle the last lane leaves, with no bubble.
- out_data is a pure mux of registers. Non-empty lanes keep their relative order. Bytes inside a lane are passed unchanged; no byte-level packing.
- beat_count increments on every out_valid && out_ready.

## Timing
- Reset (rst_n=0 at clk edge): full=0, sel=0, held data/keep/last=0, beat_count=0. Therefore out_valid=0, out_data=0, out_keep=0, out_last=0, in_ready=1 from the first cycle after reset.
- Reset mid-packet drops the held beat. No output beat completes in the reset cycle.
- Latency: a beat captured at edge N presents its first lane from N until accepted, i.e. visible in the cycle after capture.
- Throughput: one output beat per cycle when out_ready=1. A full-keep wide beat takes RATIO cycles; a wide beat with m non-empty lanes takes m cycles.
- Only combinational in→out path: out_ready → in_ready.
- out_valid, out_data, out_keep and out_last stay stable while out_valid && !out_ready (AXI rule).
- Stalled output with full=1: in_ready=0; input held off indefinitely.
- sel never exceeds RATIO-1. beat_count wraps 0xFFFFFFFF→0.

## Test plan
- RATIO=2, OUT_BYTES=64; two full-keep wide beats, second with last; out_ready=1 → 4 output beats, lanes 0,1,0,1, out_last only on the 4th, keep=all-ones, in_ready low exactly 1 cycle per wide beat, beat_count=4.
- RATIO=4; single beat with keep lanes {0,2} non-empty, last=1 → 2 output beats (lane0, lane2), out_last on lane2; lanes 1 and 3 never appear.
- Non-last beat with keep=0 → accepted, no output. Last beat with keep=0 → one beat with keep=0, last=1.
- Random out_ready backpressure (50%) over 1000 random wide beats → output equals a reference model of non-empty lanes in order, with data stable under stall and no beat loss or duplication.
- Assert rst_n=0 while a beat is half-emitted → next cycle out_valid=0, in_ready=1, beat_count=0. A new packet afterwards emits cleanly from lane 0.
- Force beat_count to 0xFFFFFFFF, transfer one beat → beat_count=0.

Source files
------------

// File: rtl/axis_width_downconverter.sv
// rtl/axis_width_downconverter.sv - wide-to-narrow AXI4-Stream converter with empty-lane skipping
module axis_width_downconverter #(
  parameter int OUT_BYTES = 64,
  parameter int RATIO     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [8*OUT_BYTES*RATIO-1:0] in_data,
  input  logic [OUT_BYTES*RATIO-1:0]   in_keep,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [8*OUT_BYTES-1:0]       out_data,
  output logic [OUT_BYTES-1:0]         out_keep,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  output logic [31:0]                  beat_count
);
  localparam int LANE_W = 8 * OUT_BYTES;
  localparam int SEL_W  = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic                         full_q, full_d;
  logic [SEL_W-1:0]             sel_q, sel_d;
  logic [LANE_W*RATIO-1:0]      data_q, data_d;
  logic [OUT_BYTES*RATIO-1:0]   keep_q, keep_d;
  logic                         last_q, last_d;
  logic [RATIO-1:0]             nz_q, nz_d;
  logic [31:0]                  beat_count_q, beat_count_d;

  logic [RATIO-1:0]             in_nz;
  logic [SEL_W-1:0]             in_first;
  logic [SEL_W-1:0]             sel_next;
  logic                         more_above;
  logic                         is_final;
  logic                         in_fire;
  logic                         out_fire;

  // Descending scans leave the lowest qualifying lane in in_first / sel_next.
  always_comb begin
    in_nz      = '0;
    in_first   = '0;
    sel_next   = sel_q;
    more_above = 1'b0;
    for (int k = RATIO - 1; k >= 0; k--) begin
      in_nz[k] = |in_keep[k*OUT_BYTES +: OUT_BYTES];
      if (in_nz[k]) begin
        in_first = SEL_W'(k);
      end
      if (nz_q[k] && (k > int'(sel_q))) begin
        more_above = 1'b1;
        sel_next   = SEL_W'(k);
      end
    end
  end

  // A held zero-keep last beat has no nz bits, so it is final by construction.
  assign is_final  = !more_above;
  assign out_valid = full_q;
  assign out_fire  = full_q && out_ready;
  assign in_ready  = !full_q || (out_ready && is_final);
  assign in_fire   = in_valid && in_ready;
  assign out_last  = full_q && last_q && is_final;
  assign beat_count = beat_count_q;

  always_comb begin
    out_data = '0;
    out_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (SEL_W'(k) == sel_q) begin
        out_data = data_q[k*LANE_W +: LANE_W];
        out_keep = keep_q[k*OUT_BYTES +: OUT_BYTES];
      end
    end
  end

  always_comb begin
    full_d       = full_q;
    sel_d        = sel_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    nz_d         = nz_q;
    beat_count_d = beat_count_q + 32'(out_fire);
    if (out_fire) begin
      if (is_final) begin
        full_d = 1'b0;
      end else begin
        sel_d = sel_next;
      end
    end
    if (in_fire) begin
      if ((|in_nz) || in_last) begin
        full_d = 1'b1;
        data_d = in_data;
        keep_d = in_keep;
        last_d = in_last;
        nz_d   = in_nz;
        sel_d  = in_first;
      end else begin
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q       <= 1'b0;
      sel_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      nz_q         <= '0;
      beat_count_q <= '0;
    end else begin
      full_q       <= full_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      nz_q         <= nz_d;
      beat_count_q <= beat_count_d;
    end
  end
endmodule

// File: tb/tb_axis_width_downconverter.sv
// tb/tb_axis_width_downconverter.sv - directed and randomised checks of axis_width_downconverter
module tb_axis_width_downconverter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // DUT A: RATIO=2, OUT_BYTES=64
  logic          a_rst_n = 1'b0;
  logic [1023:0] a_in_data = '0;
  logic [127:0]  a_in_keep = '0;
  logic          a_in_valid = 1'b0, a_in_last = 1'b0, a_in_ready;
  logic [511:0]  a_out_data;
  logic [63:0]   a_out_keep;
  logic          a_out_valid, a_out_last;
  logic          a_out_ready = 1'b0;
  logic [31:0]   a_beat_count;

  axis_width_downconverter #(.OUT_BYTES(64), .RATIO(2)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_keep(a_in_keep),
    .in_valid(a_in_valid), .in_last(a_in_last), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_keep(a_out_keep), .out_valid(a_out_valid),
    .out_last(a_out_last), .out_ready(a_out_ready), .beat_count(a_beat_count)
  );

  // DUT B: RATIO=4, OUT_BYTES=4
  logic          b_rst_n = 1'b0;
  logic [127:0]  b_in_data = '0;
  logic [15:0]   b_in_keep = '0;
  logic          b_in_valid = 1'b0, b_in_last = 1'b0, b_in_ready;
  logic [31:0]   b_out_data;
  logic [3:0]    b_out_keep;
  logic          b_out_valid, b_out_last;
  logic          b_dir_ready = 1'b0, b_rnd_ready = 1'b0, b_rnd_en = 1'b0;
  logic          b_out_ready;
  logic [31:0]   b_beat_count;

  assign b_out_ready = b_rnd_en ? b_rnd_ready : b_dir_ready;

  axis_width_downconverter #(.OUT_BYTES(4), .RATIO(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_keep(b_in_keep),
    .in_valid(b_in_valid), .in_last(b_in_last), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_keep(b_out_keep), .out_valid(b_out_valid),
    .out_last(b_out_last), .out_ready(b_out_ready), .beat_count(b_beat_count)
  );

  initial begin
    forever begin
      @(posedge clk);
      #1;
      b_rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output collectors and stall-stability monitor, sampled mid-cycle.
  logic [511:0] a_q_data[$];
  logic [63:0]  a_q_keep[$];
  logic         a_q_last[$];
  int           a_ready_low = 0;
  logic         a_count_en = 1'b0;
  logic [31:0]  b_q_data[$];
  logic [3:0]   b_q_keep[$];
  logic         b_q_last[$];
  int           b_stall_err = 0;
  logic         b_prev_stall = 1'b0;
  logic [31:0]  b_prev_data = '0;
  logic [3:0]   b_prev_keep = '0;
  logic         b_prev_last = 1'b0;

  always @(negedge clk) begin
    if (a_rst_n) begin
      if (a_out_valid && a_out_ready) begin
        a_q_data.push_back(a_out_data);
        a_q_keep.push_back(a_out_keep);
        a_q_last.push_back(a_out_last);
      end
      if (a_count_en && !a_in_ready) a_ready_low <= a_ready_low + 1;
    end
    if (b_rst_n) begin
      if (b_out_valid && b_out_ready) begin
        b_q_data.push_back(b_out_data);
        b_q_keep.push_back(b_out_keep);
        b_q_last.push_back(b_out_last);
      end
      if (b_prev_stall && (b_out_valid !== 1'b1 || b_out_data !== b_prev_data ||
                           b_out_keep !== b_prev_keep || b_out_last !== b_prev_last))
        b_stall_err <= b_stall_err + 1;
      b_prev_stall <= b_out_valid && !b_out_ready;
      b_prev_data  <= b_out_data;
      b_prev_keep  <= b_out_keep;
      b_prev_last  <= b_out_last;
    end else begin
      b_prev_stall <= 1'b0;
    end
  end

  task automatic send_a(input logic [1023:0] d, input logic [127:0] k, input logic l);
    int t = 0;
    a_in_data = d; a_in_keep = k; a_in_last = l; a_in_valid = 1'b1;
    @(negedge clk);
    while (!a_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!a_in_ready) check("a_send_timeout", 1, 0);
    @(posedge clk);
    #1 a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [127:0] d, input logic [15:0] k, input logic l);
    int t = 0;
    b_in_data = d; b_in_keep = k; b_in_last = l; b_in_valid = 1'b1;
    @(negedge clk);
    while (!b_in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!b_in_ready) check("b_send_timeout", 1, 0);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
  endtask

  function automatic logic [511:0] alane(input int i);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(i);
    return {16{w}};
  endfunction

  logic [31:0] b_exp_data[$];
  logic [3:0]  b_exp_keep[$];
  logic        b_exp_last[$];

  initial begin
    logic [127:0] rd;
    logic [15:0]  rk;
    logic         rl;
    int           mism;
    int           t;
    int           last_nz;

    repeat (2) @(posedge clk);
    #1 a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
    check("a_rst_valid", a_out_valid, 0);
    check("a_rst_data", a_out_data, 0);
    check("a_rst_keep", a_out_keep, 0);
    check("a_rst_last", a_out_last, 0);
    check("a_rst_ready", a_in_ready, 1);
    check("a_rst_count", a_beat_count, 0);
    check("b_rst_valid", b_out_valid, 0);
    check("b_rst_ready", b_in_ready, 1);

    // Two full-keep wide beats on the 2:1 instance.
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    a_count_en  = 1'b1;
    send_a({alane(1), alane(0)}, '1, 1'b0);
    send_a({alane(3), alane(2)}, '1, 1'b1);
    repeat (4) @(posedge clk);
    #1 a_count_en = 1'b0;
    check("a_n_beats", a_q_data.size(), 4);
    for (int i = 0; i < 4 && i < a_q_data.size(); i++) begin
      check($sformatf("a_data%0d", i), a_q_data[i], alane(i));
      check($sformatf("a_keep%0d", i), a_q_keep[i], {64{1'b1}});
      check($sformatf("a_last%0d", i), a_q_last[i], (i == 3));
    end
    check("a_ready_low", a_ready_low, 2);
    check("a_count4", a_beat_count, 4);

    // beat_count wrap.
    @(negedge clk);
    force dut_a.beat_count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut_a.beat_count_q;
    check("a_forced", a_beat_count, 32'hFFFF_FFFF);
    send_a({alane(5), alane(4)}, '1, 1'b1);
    @(posedge clk); #1;
    check("a_wrap0", a_beat_count, 0);
    @(posedge clk); #1;
    check("a_wrap1", a_beat_count, 1);

    // Sparse keep on the 4:1 instance: lanes 0 and 2 only.
    b_dir_ready = 1'b1;
    send_b({32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000}, 16'h030F, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("b_sparse_n", b_q_data.size(), 2);
    if (b_q_data.size() == 2) begin
      check("b_sparse_d0", b_q_data[0], 32'hDDDD0000);
      check("b_sparse_k0", b_q_keep[0], 4'hF);
      check("b_sparse_l0", b_q_last[0], 0);
      check("b_sparse_d1", b_q_data[1], 32'hDDDD0002);
      check("b_sparse_k1", b_q_keep[1], 4'h3);
      check("b_sparse_l1", b_q_last[1], 1);
    end
    b_q_data.delete(); b_q_keep.delete(); b_q_last.delete();

    // Empty beats: non-last discarded, last emits one zero-keep beat.
    send_b(128'h1234, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("b_empty_nolast", b_q_data.size(), 0);
    send_b({32'hEEEE0003, 32'hEEEE0002, 32'hEEEE0001, 32'hEEEE0000}, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("b_empty_last_n", b_q_data.size(), 1);
    if (b_q_data.size() == 1) begin
      check("b_empty_last_k", b_q_keep[0], 0);
      check("b_empty_last_l", b_q_last[0], 1);
    end
    check("b_count3", b_beat_count, 3);
    b_q_data.delete(); b_q_keep.delete(); b_q_last.delete();

    // Random traffic with random backpressure against a lane model.
    b_rnd_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      rd = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 2))
          0: rk[k*4 +: 4] = 4'h0;
          1: rk[k*4 +: 4] = 4'hF;
          default: rk[k*4 +: 4] = 4'($urandom);
        endcase
      end
      rl = ($urandom_range(0, 3) == 0);
      last_nz = -1;
      for (int k = 0; k < 4; k++) if (rk[k*4 +: 4] != 0) last_nz = k;
      if (last_nz < 0) begin
        if (rl) begin
          b_exp_data.push_back(rd[31:0]);
          b_exp_keep.push_back(4'h0);
          b_exp_last.push_back(1'b1);
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (rk[k*4 +: 4] != 0) begin
            b_exp_data.push_back(rd[k*32 +: 32]);
            b_exp_keep.push_back(rk[k*4 +: 4]);
            b_exp_last.push_back(rl && (k == last_nz));
          end
        end
      end
      send_b(rd, rk, rl);
    end
    t = 0;
    while (b_q_data.size() < b_exp_data.size() && t < 5000) begin
      @(posedge clk);
      t++;
    end
    repeat (10) @(posedge clk);
    #1 b_rnd_en = 1'b0;
    check("rnd_count", b_q_data.size(), b_exp_data.size());
    mism = 0;
    for (int i = 0; i < b_q_data.size() && i < b_exp_data.size(); i++) begin
      if (b_q_data[i] !== b_exp_data[i] || b_q_keep[i] !== b_exp_keep[i] ||
          b_q_last[i] !== b_exp_last[i]) mism++;
    end
    check("rnd_mismatches", mism, 0);
    check("rnd_stall_stable", b_stall_err, 0);
    check("rnd_beat_count", b_beat_count, 32'(3 + b_exp_data.size()));
    b_q_data.delete(); b_q_keep.delete(); b_q_last.delete();

    // Reset while a wide beat is half emitted.
    b_dir_ready = 1'b1;
    send_b({32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 16'hFFFF, 1'b1);
    @(posedge clk);
    #1 b_rst_n = 1'b0;
    @(posedge clk);
    #1 b_rst_n = 1'b1;
    check("rst_mid_valid", b_out_valid, 0);
    check("rst_mid_ready", b_in_ready, 1);
    check("rst_mid_count", b_beat_count, 0);
    check("rst_mid_emitted", b_q_data.size(), 1);
    b_q_data.delete(); b_q_keep.delete(); b_q_last.delete();
    send_b({32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000}, 16'hFFFF, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_n", b_q_data.size(), 4);
    if (b_q_data.size() == 4) begin
      check("post_rst_d0", b_q_data[0], 32'hBBBB0000);
      check("post_rst_d3", b_q_data[3], 32'hBBBB0003);
      check("post_rst_l3", b_q_last[3], 1);
    end
    check("post_rst_count", b_beat_count, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
